// File: rtl/lcd_driver.sv
// HD44780-style character LCD driver: runs the power-on init sequence, then
// serialises queued command/data bytes onto the panel with E-pulse timing.
module lcd_driver #(
    parameter int INIT_WAIT  = 20000,
    parameter int E_PULSE    = 8,
    parameter int CMD_WAIT   = 2000,
    parameter int CLEAR_WAIT = 80000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        isCmd,
    input  logic        we,
    output logic        ready,
    output logic        busy,
    output logic [10:0] lcdPins
);

    typedef enum logic [2:0] {
        INIT_DLY,
        INIT_SEND,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int MAX_A = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int MAX_B = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_WAIT - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(E_PULSE - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      init_idx;
    logic            long_wait;
    logic            rs;
    logic            e;
    logic [7:0]      d;

    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [8:0]      head;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    init_cmd = 8'h38;
            3'd1:    init_cmd = 8'h0C;
            3'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Clear and return-home need the much longer execution delay.
    function automatic logic needs_long(input logic cmd, input logic [7:0] b);
        needs_long = cmd && ((b == 8'h01) || (b == 8'h02));
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = we && !full;
    assign pop   = (state == IDLE) && !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign ready   = !full;
    assign busy    = !((state == IDLE) && empty);
    assign lcdPins = {rs, 1'b0, e, d};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {isCmd, data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // One counter is shared by the init delay, E pulse and post-transfer wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT_DLY;
            cnt       <= '0;
            init_idx  <= '0;
            long_wait <= 1'b0;
            rs        <= 1'b0;
            e         <= 1'b0;
            d         <= '0;
        end else begin
            case (state)
                INIT_DLY: begin
                    if (cnt == INIT_LAST) begin
                        cnt   <= '0;
                        state <= INIT_SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_SEND: begin
                    rs        <= 1'b0;
                    d         <= init_cmd(init_idx);
                    long_wait <= needs_long(1'b1, init_cmd(init_idx));
                    init_idx  <= init_idx + 1'b1;
                    state     <= SETUP;
                end
                IDLE: begin
                    if (!empty) begin
                        rs        <= !head[8];
                        d         <= head[7:0];
                        long_wait <= needs_long(head[8], head[7:0]);
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    e     <= 1'b1;
                    cnt   <= '0;
                    state <= PULSE;
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        e     <= 1'b0;
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // init_idx reaches 4 only once the last init command is loaded
                    if ((long_wait && (cnt == CLEAR_LAST)) || (!long_wait && (cnt == CMD_LAST))) begin
                        cnt   <= '0;
                        state <= (init_idx != 3'd4) ? INIT_SEND : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= INIT_DLY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_driver.sv
// Self-checking bench for lcd_driver: directed scenarios plus random writes,
// compared each cycle against a transfer-level timing model.
module tb_lcd_driver;

    localparam int INIT_WAIT  = 5;
    localparam int E_PULSE    = 2;
    localparam int CMD_WAIT   = 3;
    localparam int CLEAR_WAIT = 6;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = '0;
    logic        isCmd = 1'b0;
    logic        we = 1'b0;
    logic        ready;
    logic        busy;
    logic [10:0] lcdPins;

    int checks = 0;
    int passes = 0;

    int          t;
    int          free_at;
    int          last_load;
    int          init_idx;
    logic        last_rs;
    logic [7:0]  last_d;
    logic [8:0]  q[$];
    int          rise_q[$];
    logic        prev_e;
    logic [7:0]  init_seq [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    lcd_driver #(
        .INIT_WAIT(INIT_WAIT),
        .E_PULSE(E_PULSE),
        .CMD_WAIT(CMD_WAIT),
        .CLEAR_WAIT(CLEAR_WAIT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .isCmd(isCmd),
        .we(we),
        .ready(ready),
        .busy(busy),
        .lcdPins(lcdPins)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, t);
        end
    endtask

    task automatic model_reset();
        t         = 0;
        free_at   = INIT_WAIT + 1;
        last_load = -1;
        init_idx  = 0;
        last_rs   = 1'b0;
        last_d    = '0;
        prev_e    = 1'b0;
        q.delete();
        rise_q.delete();
    endtask

    // A transfer loaded at edge L pulses E over edges L+1..L+E_PULSE and frees
    // the driver for the next load at edge L + 3 + E_PULSE + wait.
    task automatic model_load(input logic cmd, input logic [7:0] b);
        int w;
        w = (cmd && (b == 8'h01 || b == 8'h02)) ? CLEAR_WAIT : CMD_WAIT;
        last_load = t;
        last_rs   = !cmd;
        last_d    = b;
        free_at   = t + 3 + E_PULSE + w;
    endtask

    task automatic model_edge(input logic w, input logic c, input logic [7:0] b);
        logic popping;
        popping = 1'b0;
        t++;
        if (t >= free_at) begin
            if (init_idx < 4) begin
                model_load(1'b1, init_seq[init_idx]);
                init_idx++;
            end else if (q.size() > 0) begin
                model_load(q[0][8], q[0][7:0]);
                popping = 1'b1;
            end
        end
        if (w && (q.size() < FIFO_DEPTH)) begin
            q.push_back({c, b});
        end
        if (popping) begin
            void'(q.pop_front());
        end
    endtask

    function automatic logic [10:0] exp_pins();
        logic ev;
        if (last_load < 0) begin
            return 11'h000;
        end
        ev = (t > last_load) && (t <= last_load + E_PULSE);
        return {last_rs, 1'b0, ev, last_d};
    endfunction

    task automatic compare_all();
        logic exp_busy;
        exp_busy = !((init_idx == 4) && (t >= free_at - 1) && (q.size() == 0));
        if (lcdPins[8] === 1'b1 && prev_e !== 1'b1) begin
            rise_q.push_back(t);
        end
        prev_e = lcdPins[8];
        check_output("pins", 32'(lcdPins), 32'(exp_pins()));
        check_output("busy", 32'(busy), 32'(exp_busy));
        check_output("ready", 32'(ready), 32'(q.size() < FIFO_DEPTH));
    endtask

    task automatic apply_stimulus(input logic w, input logic c, input logic [7:0] b);
        we    = w;
        isCmd = c;
        data  = b;
        @(posedge clk);
        @(negedge clk);
        model_edge(w, c, b);
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b1;
        we  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_output("rst_pins", 32'(lcdPins), 32'h0);
            check_output("rst_busy", 32'(busy), 32'h1);
            check_output("rst_ready", 32'(ready), 32'h1);
        end
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        logic seen;
        logic w;
        logic c;
        logic [7:0] b;

        model_reset();

        // Power-on init: four commands at fixed spacing, then idle.
        hold_reset(3);
        idle_cycles(45);
        if (rise_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_output("init_rise", 32'(rise_q[i]), 32'(INIT_WAIT + 2 + i * (3 + E_PULSE + CMD_WAIT)));
            end
        end else begin
            check_output("init_rise_count", 32'(rise_q.size()), 32'd4);
        end
        check_output("idle_busy", 32'(busy), 32'h0);

        // Single character write.
        apply_stimulus(1'b1, 1'b0, 8'h41);
        idle_cycles(12);

        // Burst of six writes; the sixth meets a full FIFO.
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                check_output("full_ready", 32'(ready), 32'h0);
            end
            apply_stimulus(1'b1, 1'b0, 8'(8'h10 + i));
        end
        idle_cycles(60);

        // Return-home command uses the long wait before the next byte.
        k = rise_q.size();
        apply_stimulus(1'b1, 1'b1, 8'h02);
        apply_stimulus(1'b1, 1'b0, 8'h42);
        idle_cycles(30);
        if (rise_q.size() >= k + 2) begin
            check_output("clear_gap", 32'(rise_q[k + 1] - rise_q[k]), 32'(3 + E_PULSE + CLEAR_WAIT));
        end else begin
            check_output("clear_gap_rises", 32'(rise_q.size()), 32'(k + 2));
        end

        // Byte queued during the init delay waits for init to finish.
        hold_reset(2);
        apply_stimulus(1'b1, 1'b0, 8'h55);
        idle_cycles(60);

        // Reset while E is high clears the pins without a clock edge.
        apply_stimulus(1'b1, 1'b0, 8'hA5);
        apply_stimulus(1'b1, 1'b0, 8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            apply_stimulus(1'b0, 1'b0, 8'h00);
            if (lcdPins[8] === 1'b1) begin
                seen = 1'b1;
            end
        end
        check_output("mid_e_seen", 32'(seen), 32'h1);
        if (seen) begin
            rst = 1'b1;
            #1;
            check_output("async_pins", 32'(lcdPins), 32'h0);
            check_output("async_ready", 32'(ready), 32'h1);
        end
        hold_reset(2);
        idle_cycles(45);

        // Random traffic, including commands that take the long wait.
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 3) == 0);
            b = 8'($urandom_range(0, 255));
            if (c && $urandom_range(0, 1) == 1) begin
                b = 8'($urandom_range(1, 2));
            end
            apply_stimulus(w, c, b);
        end
        idle_cycles(150);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
